input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_cond_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 111 +++++++++++
 rtl/input_conditioner.sv | 46 ++++
 tb/tb_input_conditioner.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared constants and types for the button input conditioner.
//   STABLE_CYCLES_DEF  : default debounce hold time in clock cycles
//   REPEAT_DELAY_DEF   : default cycles from press to first auto-repeat
//   REPEAT_PERIOD_DEF  : default cycles between later auto-repeats
//   btn_ch_e           : channel index of each physical button
//   rep_phase_e        : auto-repeat phase (waiting first delay / periodic)
package input_cond_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 1000000;
  localparam int unsigned REPEAT_DELAY_DEF  = 25000000;
  localparam int unsigned REPEAT_PERIOD_DEF = 10000000;

  typedef enum logic [2:0] {
    CHOP  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4
  } btn_ch_e;

  typedef enum logic {
    RepDelay,
    RepPeriod
  } rep_phase_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, debounce counter, edge pulses
// and auto-repeat generator.
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset
//   noisy     : raw asynchronous button level, 1 = pressed
//   repeat_en : auto-repeat enable
//   clean     : debounced level
//   rise/fall : one-cycle press/release pulses, aligned with clean changing
//   evt       : one-cycle action pulse (press or auto-repeat)
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  input  logic repeat_en,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic evt
);

  localparam int unsigned CntW    = $clog2(STABLE_CYCLES);
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  // One extra count of headroom so hold_inc can reach HoldMax without wrapping.
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  logic             sync1_q, sync2_q;
  logic [CntW-1:0]  stable_q, stable_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d, fall_q, fall_d, evt_q, evt_d;
  logic [HoldW-1:0] hold_q, hold_d, hold_inc;
  rep_phase_e       phase_q, phase_d;
  logic             update;
  logic             rep_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= '0;
      clean_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      evt_q    <= 1'b0;
      hold_q   <= '0;
      phase_q  <= RepDelay;
    end else begin
      sync1_q  <= noisy;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      clean_q  <= clean_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      evt_q    <= evt_d;
      hold_q   <= hold_d;
      phase_q  <= phase_d;
    end
  end

  always_comb begin
    stable_d  = stable_q;
    clean_d   = clean_q;
    update    = 1'b0;
    hold_inc  = hold_q + HoldW'(1);
    hold_d    = '0;
    phase_d   = RepDelay;
    rep_pulse = 1'b0;

    // Any return to the clean level restarts the debounce window.
    if (sync2_q == clean_q) begin
      stable_d = '0;
    end else if (stable_q == CntW'(STABLE_CYCLES - 1)) begin
      clean_d  = sync2_q;
      stable_d = '0;
      update   = 1'b1;
    end else begin
      stable_d = stable_q + CntW'(1);
    end

    rise_d = update & sync2_q;
    fall_d = update & ~sync2_q;

    // Count only while held and enabled; a clean update (press or release)
    // restarts from zero, so no repeat can coincide with a release.
    if (clean_q && repeat_en && !update) begin
      hold_d  = hold_inc;
      phase_d = phase_q;
      if (phase_q == RepDelay && hold_inc == HoldW'(REPEAT_DELAY)) begin
        rep_pulse = 1'b1;
        hold_d    = '0;
        phase_d   = RepPeriod;
      end else if (phase_q == RepPeriod && hold_inc == HoldW'(REPEAT_PERIOD)) begin
        rep_pulse = 1'b1;
        hold_d    = '0;
      end
    end

    evt_d = rise_d | rep_pulse;
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign evt   = evt_q;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button conditioner: N_CH independent debounce/auto-repeat
// channels sharing one clock and synchronous reset.
//   clock_in  : system clock, rising edge
//   reset_in  : synchronous active-high reset
//   noisy_in  : raw asynchronous button levels, 1 = pressed
//   repeat_en : per-channel auto-repeat enable
//   clean_out : debounced levels
//   rise_out  : one-cycle press pulses
//   fall_out  : one-cycle release pulses
//   event_out : one-cycle action pulses (press or auto-repeat)
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned N_CH          = 5,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic            clock_in,
  input  logic            reset_in,
  input  logic [N_CH-1:0] noisy_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] clean_out,
  output logic [N_CH-1:0] rise_out,
  output logic [N_CH-1:0] fall_out,
  output logic [N_CH-1:0] event_out
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clock_in),
      .rst      (reset_in),
      .noisy    (noisy_in[i]),
      .repeat_en(repeat_en[i]),
      .clean    (clean_out[i]),
      .rise     (rise_out[i]),
      .fall     (fall_out[i]),
      .evt      (event_out[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (N_CH=5, STABLE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3). Stimulus pushes timed expectations;
// a negedge monitor compares them on the cycle they fall due.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int unsigned NCh = 5;
  localparam int unsigned Lat = 6;  // 2 sync stages + STABLE_CYCLES

  typedef enum int {SelClean, SelRise, SelFall, SelEvent} sel_e;
  typedef struct {
    int         cyc;
    string      tag;
    sel_e       sel;
    logic [4:0] mask;
    logic [4:0] exp;
  } sb_item_t;

  logic           clk;
  logic           rst;
  logic [NCh-1:0] noisy;
  logic [NCh-1:0] ren;
  logic [NCh-1:0] clean, rise, fall, evt;

  int       cyc;
  int       n_checks;
  int       n_errors;
  sb_item_t sb[$];

  input_conditioner #(
    .N_CH         (NCh),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clock_in (clk),
    .reset_in (rst),
    .noisy_in (noisy),
    .repeat_en(ren),
    .clean_out(clean),
    .rise_out (rise),
    .fall_out (fall),
    .event_out(evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] pick(input sel_e s);
    case (s)
      SelClean: pick = clean;
      SelRise:  pick = rise;
      SelFall:  pick = fall;
      default:  pick = evt;
    endcase
  endfunction

  function automatic logic [4:0] bit_of(input int ch);
    bit_of = 5'b00001 << ch;
  endfunction

  task automatic expect_at(input int c, input sel_e s, input logic [4:0] m,
                           input logic [4:0] e, input string tag);
    sb_item_t it;
    it.cyc  = c;
    it.tag  = tag;
    it.sel  = s;
    it.mask = m;
    it.exp  = e;
    sb.push_back(it);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].cyc < cyc) check({sb[i].tag, "_missed"}, 32'(sb[i].cyc), 32'(cyc));
        else check(sb[i].tag, 32'(pick(sb[i].sel) & sb[i].mask), 32'(sb[i].exp & sb[i].mask));
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, e0, r;
    logic [4:0] m;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    noisy = '0;
    ren   = '0;
    tick(2);
    for (int s = 0; s < 4; s++) expect_at(cyc, sel_e'(s), 5'h1f, 5'h00, "reset_zero");
    tick(1);
    rst = 1'b0;
    tick(2);

    // Single press/release on CHOP: exact latency and one-cycle pulses.
    m = bit_of(int'(CHOP));
    c = cyc;
    noisy[0] = 1'b1;
    expect_at(c + Lat - 1, SelClean, m, 5'h00, "ch0_clean_early");
    expect_at(c + Lat,     SelClean, m, m,     "ch0_clean_rise");
    expect_at(c + Lat - 1, SelRise,  m, 5'h00, "ch0_rise_early");
    expect_at(c + Lat,     SelRise,  m, m,     "ch0_rise");
    expect_at(c + Lat + 1, SelRise,  m, 5'h00, "ch0_rise_width");
    expect_at(c + Lat,     SelEvent, m, m,     "ch0_event_press");
    tick(12);
    c = cyc;
    noisy[0] = 1'b0;
    expect_at(c + Lat - 1, SelFall,  m, 5'h00, "ch0_fall_early");
    expect_at(c + Lat,     SelFall,  m, m,     "ch0_fall");
    expect_at(c + Lat + 1, SelFall,  m, 5'h00, "ch0_fall_width");
    expect_at(c + Lat,     SelClean, m, 5'h00, "ch0_clean_fall");
    expect_at(c + Lat,     SelEvent, m, 5'h00, "ch0_no_event_release");
    tick(12);

    // Three-cycle glitch on LEFT must be rejected.
    m = bit_of(int'(LEFT));
    c = cyc;
    noisy[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      expect_at(c + k, SelClean, m, 5'h00, "ch1_glitch_clean");
      expect_at(c + k, SelRise,  m, 5'h00, "ch1_glitch_rise");
      expect_at(c + k, SelEvent, m, 5'h00, "ch1_glitch_event");
    end
    tick(3);
    noisy[1] = 1'b0;
    tick(12);

    // Auto-repeat on RIGHT: press, +10, +13, +16.
    m = bit_of(int'(RIGHT));
    ren[2] = 1'b1;
    c = cyc;
    noisy[2] = 1'b1;
    e0 = c + Lat;
    expect_at(e0,      SelEvent, m, m,     "ch2_ev_press");
    expect_at(e0 + 1,  SelEvent, m, 5'h00, "ch2_ev_gap1");
    expect_at(e0 + 9,  SelEvent, m, 5'h00, "ch2_ev_pre10");
    expect_at(e0 + 10, SelEvent, m, m,     "ch2_ev_rep10");
    expect_at(e0 + 11, SelEvent, m, 5'h00, "ch2_ev_gap11");
    expect_at(e0 + 12, SelEvent, m, 5'h00, "ch2_ev_gap12");
    expect_at(e0 + 13, SelEvent, m, m,     "ch2_ev_rep13");
    expect_at(e0 + 14, SelEvent, m, 5'h00, "ch2_ev_gap14");
    expect_at(e0 + 16, SelEvent, m, m,     "ch2_ev_rep16");
    expect_at(e0 + 10, SelRise,  m, 5'h00, "ch2_rep_not_rise");
    tick_to(e0 + 17);
    noisy[2] = 1'b0;
    ren[2]   = 1'b0;
    tick(12);

    // repeat_en dropped at +12, re-raised at +20 -> next repeat at +30.
    ren[2] = 1'b1;
    c = cyc;
    noisy[2] = 1'b1;
    e0 = c + Lat;
    expect_at(e0,      SelEvent, m, m,     "ch2b_ev_press");
    expect_at(e0 + 10, SelEvent, m, m,     "ch2b_ev_rep10");
    expect_at(e0 + 13, SelEvent, m, 5'h00, "ch2b_ev_suppressed13");
    expect_at(e0 + 16, SelEvent, m, 5'h00, "ch2b_ev_suppressed16");
    expect_at(e0 + 29, SelEvent, m, 5'h00, "ch2b_ev_pre30");
    expect_at(e0 + 30, SelEvent, m, m,     "ch2b_ev_rep30");
    expect_at(e0 + 33, SelEvent, m, m,     "ch2b_ev_rep33");
    tick_to(e0 + 12);
    ren[2] = 1'b0;
    tick_to(e0 + 20);
    ren[2] = 1'b1;
    tick_to(e0 + 34);
    noisy[2] = 1'b0;
    ren[2]   = 1'b0;
    tick(12);

    // UP held through reset: outputs cleared, fresh press after release.
    m = bit_of(int'(UP));
    noisy[3] = 1'b1;
    tick(10);
    c = cyc;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      for (int s = 0; s < 4; s++) expect_at(c + k, sel_e'(s), 5'h1f, 5'h00, "reset_mid_hold");
    end
    tick(3);
    rst = 1'b0;
    r = cyc;
    expect_at(r + Lat - 1, SelRise,  m, 5'h00, "ch3_rise_early");
    expect_at(r + Lat - 1, SelClean, m, 5'h00, "ch3_clean_early");
    expect_at(r + Lat,     SelRise,  m, m,     "ch3_rise_after_reset");
    expect_at(r + Lat,     SelEvent, m, m,     "ch3_event_after_reset");
    tick(10);
    noisy[3] = 1'b0;
    tick(12);

    // Simultaneous presses on CHOP and DOWN.
    c = cyc;
    noisy[int'(CHOP)] = 1'b1;
    noisy[int'(DOWN)] = 1'b1;
    expect_at(c + Lat - 1, SelRise,  5'h1f, 5'b00000, "multi_rise_early");
    expect_at(c + Lat,     SelRise,  5'h1f, 5'b10001, "multi_rise");
    expect_at(c + Lat,     SelEvent, 5'h1f, 5'b10001, "multi_event");
    expect_at(c + Lat + 1, SelRise,  5'h1f, 5'b00000, "multi_rise_width");
    tick(10);
    noisy = '0;
    tick(12);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
